alu_core: RTL and testbench
===========================

Name: alu_core

Overview:
- 32-bit integer ALU for the CPU datapath, MIPS-style operation set selected by a 4-bit mode code.
- Result `z` is combinational from `x`, `y`, `mode` and the internal HI register.
- HI register is the only state; it captures the MUL high word or the DIV remainder, and MFHI reads it.
- Sits in the execute stage between register-file read ports and writeback.

Parameters:
- N, 32, datapath width; all arithmetic rules below are stated for N=32.

Ports:
- clk  input  1  rising-edge clock (HI register only)
- rst_n  input  1  synchronous active-low reset
- x  input  N  operand A
- y  input  N  operand B
- mode  input  4  operation select
- z  output  N  result (combinational)

Behaviour:
- Reset: on a clk rising edge with rst_n=0, HI <= 0.
  - `z` has no reset value; it always reflects the current inputs.
  - Reset has priority over a HI write in the same cycle.
- Mode map (`z` result):
  - 0000 NOP: z=0.
  - 0001 ADD: z=x+y, modulo 2^N, no overflow flag.
  - 0010 SUB: z=x-y, modulo 2^N.
  - 0011 MUL: signed 32x32->64 product P; z=P[31:0]; HI <= P[63:32] at the next clk edge.
  - 0100 DIV: signed quotient truncated toward zero; z=quotient; HI <= remainder at the next edge (remainder takes the sign of x).
  - 0101 AND: z=x&y.
  - 0110 OR: z=x|y.
  - 0111 XOR: z=x^y.
  - 1000 NOR: z=~(x|y).
  - 1001 SLL: z=x<<y[4:0].
  - 1010 SRL: logical shift, z=x>>y[4:0], zero fill.
  - 1011 SLT: z=1 if signed x<signed y, else 0.
  - 1100 reserved: z=0.
  - 1101 MFHI: z=HI (registered value, no bypass).
  - 1110 EQ: z=(x==y)?1:0.
  - 1111 NEQ: z=(x!=y)?1:0.
- HI write rules:
  - HI updates only on a clk edge with rst_n=1 and mode in {MUL, DIV}; all other modes hold HI.
  - MUL/DIV `z` is valid combinationally in the same cycle.
  - An MFHI issued in the cycle after MUL/DIV returns the new HI.
  - MFHI in the same cycle as MUL/DIV is impossible (single mode).
- DIV corner cases:
  - y=0: quotient=0xFFFFFFFF, remainder=x.
  - x=0x80000000 and y=0xFFFFFFFF: quotient=0x80000000, remainder=0.
- Flag results (SLT/EQ/NEQ) are zero-extended to N bits.
- Shift amounts use only y[4:0]; y[31:5] are ignored.
- No X propagation: every mode value yields a defined `z`.

Test Plan:
- Reset then MFHI: hold rst_n=0 for one edge, release, mode=1101 -> z=0x00000000.
- x=0x33333333, y=0x02222222:
  - ADD -> 0x35555555; SUB -> 0x31111111.
  - MUL -> z=0xCC5F92C6; after the edge, MFHI -> 0x006D3A06.
  - DIV -> z=0x00000018; after the edge, MFHI -> 0x00000003.
- Same operands, logic and shift modes:
  - AND -> 0x02222222; OR -> 0x33333333; XOR -> 0x31111111; NOR -> 0xCCCCCCCC.
  - SLL -> 0xCCCCCCCC; SRL -> 0x0CCCCCCC.
- Compare modes:
  - SLT x=0x33333333, y=0x02222222 -> 0; SLT x=0x33333333, y=0xFFFFFFFF -> 0 (signed); SLT x=0xFFFFFFFF, y=0x00000001 -> 1.
  - EQ with y=0x02222222 -> 0; EQ with y=0x33333333 -> 1.
  - NEQ with y=0x02222222 -> 1; NEQ with y=0x33333333 -> 0.
- DIV corners: x=7, y=0 -> z=0xFFFFFFFF, then MFHI -> 7; x=0x80000000, y=0xFFFFFFFF -> z=0x80000000, then MFHI -> 0.
- HI hold/reset: MUL, then ADD for several cycles, then MFHI -> still the MUL high word; assert rst_n=0 during a MUL cycle -> MFHI afterwards returns 0.

Source files
------------

// File: rtl/alu_core.sv
// 32-bit MIPS-style execute-stage ALU with a HI register for the MUL high word
// and the DIV remainder; the result z is purely combinational.
module alu_core #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic [3:0]   mode,
    output logic [N-1:0] z
);

    typedef enum logic [3:0] {
        OP_NOP  = 4'b0000,
        OP_ADD  = 4'b0001,
        OP_SUB  = 4'b0010,
        OP_MUL  = 4'b0011,
        OP_DIV  = 4'b0100,
        OP_AND  = 4'b0101,
        OP_OR   = 4'b0110,
        OP_XOR  = 4'b0111,
        OP_NOR  = 4'b1000,
        OP_SLL  = 4'b1001,
        OP_SRL  = 4'b1010,
        OP_SLT  = 4'b1011,
        OP_RSV  = 4'b1100,
        OP_MFHI = 4'b1101,
        OP_EQ   = 4'b1110,
        OP_NEQ  = 4'b1111
    } op_e;

    localparam int SHW = $clog2(N);

    // Unsigned restoring division; returns {remainder, quotient}.
    function automatic logic [2*N-1:0] udivmod(input logic [N-1:0] num,
                                               input logic [N-1:0] den);
        logic [N:0]   rem;
        logic [N-1:0] quo;
        rem = '0;
        quo = '0;
        for (int i = N - 1; i >= 0; i--) begin
            rem = {rem[N-1:0], num[i]};
            if (rem >= {1'b0, den}) begin
                rem    = rem - {1'b0, den};
                quo[i] = 1'b1;
            end
        end
        return {rem[N-1:0], quo};
    endfunction

    op_e            op;
    logic [N-1:0]   hi_q;
    logic [N-1:0]   hi_d;
    logic           hi_we;
    logic [2*N-1:0] prod;
    logic [N-1:0]   x_mag;
    logic [N-1:0]   y_mag;
    logic [2*N-1:0] udiv;
    logic [N-1:0]   quo;
    logic [N-1:0]   rem;
    logic [SHW-1:0] shamt;

    assign op    = op_e'(mode);
    assign shamt = y[SHW-1:0];

    // Sign-extending both operands to 2N bits makes an unsigned multiply
    // produce the exact signed 2N-bit product.
    assign prod = {{N{x[N-1]}}, x} * {{N{y[N-1]}}, y};

    assign x_mag = x[N-1] ? -x : x;
    assign y_mag = y[N-1] ? -y : y;
    assign udiv  = udivmod(x_mag, y_mag);

    // Magnitude divide then re-sign: truncates toward zero, remainder follows x,
    // and the most-negative / -1 case falls out as 0x80000000 with remainder 0.
    always_comb begin
        quo = (x[N-1] ^ y[N-1]) ? -udiv[N-1:0] : udiv[N-1:0];
        rem = x[N-1] ? -udiv[2*N-1:N] : udiv[2*N-1:N];
        if (y == '0) begin
            quo = '1;
            rem = x;
        end
    end

    // NOTE: every variable written in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        hi_we = 1'b0;
        hi_d  = hi_q;
        if (op == OP_MUL) begin
            hi_we = 1'b1;
            hi_d  = prod[2*N-1:N];
        end else if (op == OP_DIV) begin
            hi_we = 1'b1;
            hi_d  = rem;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi_q <= '0;
        end else if (hi_we) begin
            hi_q <= hi_d;
        end
    end

    always_comb begin
        z = '0;
        case (op)
            OP_NOP:  z = '0;
            OP_ADD:  z = x + y;
            OP_SUB:  z = x - y;
            OP_MUL:  z = prod[N-1:0];
            OP_DIV:  z = quo;
            OP_AND:  z = x & y;
            OP_OR:   z = x | y;
            OP_XOR:  z = x ^ y;
            OP_NOR:  z = ~(x | y);
            OP_SLL:  z = x << shamt;
            OP_SRL:  z = x >> shamt;
            OP_SLT:  z = {{(N-1){1'b0}}, ($signed(x) < $signed(y))};
            OP_RSV:  z = '0;
            OP_MFHI: z = hi_q;
            OP_EQ:   z = {{(N-1){1'b0}}, (x == y)};
            OP_NEQ:  z = {{(N-1){1'b0}}, (x != y)};
            default: z = '0;
        endcase
    end

endmodule

// File: tb/tb_alu_core.sv
// Scoreboard bench for alu_core: directed operations from the test plan, then
// random operations checked against a behavioural model with its own HI copy.
module tb_alu_core;

    localparam int N = 32;

    localparam logic [3:0] M_NOP  = 4'b0000;
    localparam logic [3:0] M_ADD  = 4'b0001;
    localparam logic [3:0] M_SUB  = 4'b0010;
    localparam logic [3:0] M_MUL  = 4'b0011;
    localparam logic [3:0] M_DIV  = 4'b0100;
    localparam logic [3:0] M_AND  = 4'b0101;
    localparam logic [3:0] M_OR   = 4'b0110;
    localparam logic [3:0] M_XOR  = 4'b0111;
    localparam logic [3:0] M_NOR  = 4'b1000;
    localparam logic [3:0] M_SLL  = 4'b1001;
    localparam logic [3:0] M_SRL  = 4'b1010;
    localparam logic [3:0] M_SLT  = 4'b1011;
    localparam logic [3:0] M_MFHI = 4'b1101;
    localparam logic [3:0] M_EQ   = 4'b1110;
    localparam logic [3:0] M_NEQ  = 4'b1111;

    typedef struct {
        string        tag;
        logic [N-1:0] exp;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic [3:0]   mode;
    logic [N-1:0] z;

    exp_t         sb_q[$];
    int           n_checks = 0;
    int           n_fail   = 0;
    logic [N-1:0] hi_model;

    alu_core #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .x     (x),
        .y     (y),
        .mode  (mode),
        .z     (z)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // One operation per cycle: drive after the rising edge, score at the
    // falling edge; the following rising edge commits any HI write.
    task automatic issue(input string tag, input logic [3:0] m, input logic [N-1:0] a,
                         input logic [N-1:0] b, input logic [N-1:0] exp,
                         input logic rst_val = 1'b1);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = rst_val;
        mode  = m;
        x     = a;
        y     = b;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
        @(negedge clk);
        e = sb_q.pop_front();
        check(e.tag, z, e.exp);
    endtask

    function automatic void model(input logic [3:0] m, input logic [N-1:0] a,
                                  input logic [N-1:0] b, input logic [N-1:0] hi_in,
                                  output logic [N-1:0] zr, output logic [N-1:0] hi_out);
        longint p;
        int     sa, sb, q, r;
        p  = longint'($signed(a)) * longint'($signed(b));
        sa = $signed(a);
        sb = $signed(b);
        if (b == 0) begin
            q = -1;
            r = sa;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = sa;
            r = 0;
        end else begin
            q = sa / sb;
            r = sa % sb;
        end
        hi_out = hi_in;
        zr     = '0;
        case (m)
            M_ADD:  zr = a + b;
            M_SUB:  zr = a - b;
            M_MUL:  begin zr = p[31:0]; hi_out = p[63:32]; end
            M_DIV:  begin zr = q; hi_out = r; end
            M_AND:  zr = a & b;
            M_OR:   zr = a | b;
            M_XOR:  zr = a ^ b;
            M_NOR:  zr = ~(a | b);
            M_SLL:  zr = a << b[4:0];
            M_SRL:  zr = a >> b[4:0];
            M_SLT:  zr = (sa < sb) ? 32'd1 : 32'd0;
            M_MFHI: zr = hi_in;
            M_EQ:   zr = (a == b) ? 32'd1 : 32'd0;
            M_NEQ:  zr = (a != b) ? 32'd1 : 32'd0;
            default: zr = '0;
        endcase
    endfunction

    initial begin
        logic [N-1:0] a, b, ez, nh;
        logic [3:0]   m;

        rst_n = 1'b0;
        mode  = M_NOP;
        x     = '0;
        y     = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        issue("reset_mfhi", M_MFHI, '0, '0, 32'h0000_0000);

        a = 32'h3333_3333;
        b = 32'h0222_2222;
        issue("add",      M_ADD,  a, b, 32'h3555_5555);
        issue("sub",      M_SUB,  a, b, 32'h3111_1111);
        issue("mul_lo",   M_MUL,  a, b, 32'hCC5F_92C6);
        issue("mul_hi",   M_MFHI, a, b, 32'h006D_3A06);
        issue("div_q",    M_DIV,  a, b, 32'h0000_0018);
        issue("div_r",    M_MFHI, a, b, 32'h0000_0003);
        issue("and",      M_AND,  a, b, 32'h0222_2222);
        issue("or",       M_OR,   a, b, 32'h3333_3333);
        issue("xor",      M_XOR,  a, b, 32'h3111_1111);
        issue("nor",      M_NOR,  a, b, 32'hCCCC_CCCC);
        issue("sll",      M_SLL,  a, b, 32'hCCCC_CCCC);
        issue("srl",      M_SRL,  a, b, 32'h0CCC_CCCC);
        issue("sll_hi_y", M_SLL,  a, 32'hFFFF_FFE2, 32'hCCCC_CCCC);
        issue("nop",      M_NOP,  a, b, 32'h0000_0000);
        issue("reserved", 4'b1100, a, b, 32'h0000_0000);

        issue("slt_pos",  M_SLT,  a, b, 32'h0000_0000);
        issue("slt_neg_y", M_SLT, a, 32'hFFFF_FFFF, 32'h0000_0000);
        issue("slt_neg_x", M_SLT, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001);
        issue("eq_ne",    M_EQ,   a, b, 32'h0000_0000);
        issue("eq_eq",    M_EQ,   a, a, 32'h0000_0001);
        issue("neq_ne",   M_NEQ,  a, b, 32'h0000_0001);
        issue("neq_eq",   M_NEQ,  a, a, 32'h0000_0000);

        issue("div0_q",   M_DIV,  32'd7, 32'd0, 32'hFFFF_FFFF);
        issue("div0_r",   M_MFHI, '0, '0, 32'h0000_0007);
        issue("divovf_q", M_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        issue("divovf_r", M_MFHI, '0, '0, 32'h0000_0000);
        issue("divneg_q", M_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        issue("divneg_r", M_MFHI, '0, '0, 32'hFFFF_FFFF);

        issue("hold_mul", M_MUL, a, b, 32'hCC5F_92C6);
        for (int i = 0; i < 4; i++) begin
            issue("hold_add", M_ADD, 32'd5, 32'd6, 32'd11);
        end
        issue("hold_mfhi", M_MFHI, '0, '0, 32'h006D_3A06);
        issue("rst_mul_lo", M_MUL, a, b, 32'hCC5F_92C6, 1'b0);
        issue("rst_mfhi",   M_MFHI, '0, '0, 32'h0000_0000);

        hi_model = '0;
        for (int i = 0; i < 200; i++) begin
            m = 4'($urandom_range(0, 15));
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = '0;
                1:       b = 32'($urandom_range(1, 40));
                2:       b = a;
                default: b = $urandom;
            endcase
            model(m, a, b, hi_model, ez, nh);
            issue("rand", m, a, b, ez);
            hi_model = nh;
        end

        check("sb_empty", N'(sb_q.size()), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
